// File: rtl/regfile_ctrl_pkg.sv
// Shared register-file control types: address width, zero register and the
// write-request record carried between the datapath and the write-port arbiter.
package regfile_ctrl_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 1 << REG_AW;

  typedef logic [REG_AW-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = 5'd0;

  typedef struct packed {
    reg_addr_t       rd;
    logic [XLEN-1:0] data;
  } wr_req_t;

  function automatic logic is_zero_reg(input reg_addr_t addr);
    return addr == ZERO_REG;
  endfunction

  // One-hot select of a register; writes to x0 decode to nothing.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_addr_t addr);
    logic [NUM_REGS-1:0] vec;
    vec = '0;
    if (!is_zero_reg(addr)) begin
      vec[addr] = 1'b1;
    end
    return vec;
  endfunction

endpackage

// File: rtl/mc_wr_fifo.sv
// Small synchronous FIFO holding multi-cycle write results until the shared
// register-file write port is free. Head entry is visible combinationally.
module mc_wr_fifo
  import regfile_ctrl_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = wr_req_t,
  parameter int  CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  output entry_t        head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr_reg];

  // Storage carries no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wport_arb.sv
// Register-file write-port arbiter: pipeline writeback has fixed priority over
// queued multi-cycle results; a busy scoreboard flags outstanding MC writes.
module regfile_wport_arb
  import regfile_ctrl_pkg::*;
#(
  parameter int N     = XLEN,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [N-1:0]      wb_data,
  input  logic              mc_valid,
  output logic              mc_ready,
  input  logic [REG_AW-1:0] mc_rd,
  input  logic [N-1:0]      mc_data,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_rd,
  input  logic [REG_AW-1:0] q1_rd,
  input  logic [REG_AW-1:0] q2_rd,
  output logic              q1_busy,
  output logic              q2_busy,
  output logic              wb_stall,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [N-1:0]      rf_wdata
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [N-1:0]      data;
  } mc_req_t;

  mc_req_t             push_req;
  mc_req_t             fifo_head;
  logic [CW-1:0]       fifo_count;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_push;
  logic                wb_grant;
  logic                mc_grant;
  logic [NUM_REGS-1:0] busy_reg;
  logic [NUM_REGS-1:0] busy_next;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;

  // mc_ready looks at the pre-pop count, so a full FIFO never pushes even
  // when its head retires on the same edge.
  assign mc_ready  = (fifo_count != CW'(DEPTH));
  assign wb_stall  = fifo_full;

  // x0 results complete the handshake but are never stored.
  assign fifo_push = mc_valid && mc_ready && !is_zero_reg(mc_rd);
  assign push_req  = '{rd: mc_rd, data: mc_data};

  mc_wr_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (mc_req_t),
    .CW      (CW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_req),
    .pop       (mc_grant),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign wb_grant = wb_valid && !is_zero_reg(wb_rd);
  assign mc_grant = !wb_grant && !fifo_empty;

  // Issue wins over retirement on the same register; x0 never becomes busy.
  assign set_vec   = iss_valid ? reg_onehot(iss_rd) : '0;
  assign clr_vec   = mc_grant ? reg_onehot(fifo_head.rd) : '0;
  assign busy_next = set_vec | (busy_reg & ~clr_vec);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign q1_busy = busy_reg[q1_rd];
  assign q2_busy = busy_reg[q2_rd];

  // Address/data hold their last value on idle cycles; only rf_we drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= wb_grant || mc_grant;
      if (wb_grant) begin
        rf_waddr <= wb_rd;
        rf_wdata <= wb_data;
      end else if (mc_grant) begin
        rf_waddr <= fifo_head.rd;
        rf_wdata <= fifo_head.data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wport_arb.sv
// Bench for regfile_wport_arb: directed scenarios then random traffic, checked
// against a queue-based model of the write port and pending-write set.
module tb_regfile_wport_arb;

  localparam int N     = 32;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_valid, mc_valid, iss_valid;
  logic [4:0]  wb_rd, mc_rd, iss_rd, q1_rd, q2_rd;
  logic [31:0] wb_data, mc_data;
  logic        mc_ready, q1_busy, q2_busy, wb_stall, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  always #5 clk = ~clk;

  regfile_wport_arb #(.N(N), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .mc_valid  (mc_valid),
    .mc_ready  (mc_ready),
    .mc_rd     (mc_rd),
    .mc_data   (mc_data),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .q1_rd     (q1_rd),
    .q2_rd     (q2_rd),
    .q1_busy   (q1_busy),
    .q2_busy   (q2_busy),
    .wb_stall  (wb_stall),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  bit          busy_m[32];
  logic        exp_we;
  logic [4:0]  exp_waddr;
  logic [31:0] exp_wdata;
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    foreach (busy_m[i]) busy_m[i] = 1'b0;
    exp_we    = 1'b0;
    exp_waddr = '0;
    exp_wdata = '0;
  endtask

  // One clock of the port rules: WB to a real register wins, else the oldest
  // queued MC result retires; accepted MC results join the back of the queue.
  task automatic model_step();
    bit   ready;
    ent_t e;
    ready = (mq.size() != DEPTH);
    if (wb_valid && wb_rd != 0) begin
      exp_we = 1'b1; exp_waddr = wb_rd; exp_wdata = wb_data;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      exp_we = 1'b1; exp_waddr = e.rd; exp_wdata = e.data;
      busy_m[e.rd] = 1'b0;
    end else begin
      exp_we = 1'b0;
    end
    if (mc_valid && ready && mc_rd != 0) begin
      e.rd = mc_rd; e.data = mc_data;
      mq.push_back(e);
    end
    if (iss_valid && iss_rd != 0) busy_m[iss_rd] = 1'b1;
  endtask

  task automatic drive(input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md,
                       input logic iv, input logic [4:0] ir, input logic [4:0] q1);
    wb_valid = wv; wb_rd = wr; wb_data = wd;
    mc_valid = mv; mc_rd = mr; mc_data = md;
    iss_valid = iv; iss_rd = ir;
    q1_rd = q1; q2_rd = 5'($urandom_range(0, 31));
  endtask

  // Called just after a falling edge with inputs applied.
  task automatic cycle();
    #1;
    check_val("mc_ready", {31'd0, mc_ready}, {31'd0, mq.size() != DEPTH});
    check_val("wb_stall", {31'd0, wb_stall}, {31'd0, mq.size() == DEPTH});
    check_val("q1_busy", {31'd0, q1_busy}, {31'd0, busy_m[q1_rd]});
    check_val("q2_busy", {31'd0, q2_busy}, {31'd0, busy_m[q2_rd]});
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    $display("cyc %0d: wb=%b/%0d mc=%b/%0d rdy=%b iss=%b/%0d -> we=%b waddr=%0d wdata=%h",
             cyc, wb_valid, wb_rd, mc_valid, mc_rd, mc_ready, iss_valid, iss_rd,
             rf_we, rf_waddr, rf_wdata);
    check_val("rf_we", {31'd0, rf_we}, {31'd0, exp_we});
    check_val("rf_waddr", {27'd0, rf_waddr}, {27'd0, exp_waddr});
    check_val("rf_wdata", rf_wdata, exp_wdata);
    @(negedge clk);
  endtask

  task automatic idle(input logic [4:0] q1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, q1);
    cycle();
  endtask

  initial begin
    model_reset();
    // Handshakes while in reset must be ignored.
    drive(1, 5'd6, 32'h55, 1, 5'd6, 32'h66, 1, 5'd6, 5'd6);
    repeat (2) @(negedge clk);
    #1;
    check_val("reset rf_we", {31'd0, rf_we}, 32'd0);
    check_val("reset rf_waddr", {27'd0, rf_waddr}, 32'd0);
    check_val("reset rf_wdata", rf_wdata, 32'd0);
    check_val("reset mc_ready", {31'd0, mc_ready}, 32'd1);
    check_val("reset wb_stall", {31'd0, wb_stall}, 32'd0);
    check_val("reset q1_busy", {31'd0, q1_busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // WB write, then an idle cycle.
    drive(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
    cycle();
    check_val("wb wdata", rf_wdata, 32'hDEADBEEF);
    idle(0);

    // Issue r7, then its MC result; busy until the retire edge.
    drive(0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7);
    cycle();
    idle(7);
    drive(0, 0, 0, 1, 5'd7, 32'h11, 0, 0, 5'd7);
    cycle();
    idle(7);
    idle(7);
    check_val("mc r7 busy after retire", {31'd0, q1_busy}, 32'd0);

    // WB and MC together: WB first, MC the cycle after.
    drive(1, 5'd3, 32'hA, 1, 5'd4, 32'hB, 0, 0, 0);
    cycle();
    idle(0);
    idle(0);

    // Continuous WB while MC pushes 1 then 2: FIFO fills and stalls.
    begin
      int k = 0;
      for (int i = 0; i < 6; i++) begin
        drive(1, 5'(10 + i), 32'h100 + i, k < 2, 5'(20 + k), 32'(k + 1), 0, 0, 0);
        if (k < 2 && mc_ready) k++;
        cycle();
      end
    end
    idle(0);
    idle(0);
    idle(0);

    // x0 traffic: nothing stored, nothing written, nothing busy.
    drive(1, 5'd0, 32'h77, 1, 5'd0, 32'h88, 1, 5'd0, 5'd0);
    cycle();
    idle(0);

    // Issue and retire of r9 in the same cycle: issue wins.
    drive(0, 0, 0, 1, 5'd9, 32'h99, 1, 5'd9, 5'd9);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 1, 5'd9, 5'd9);
    cycle();
    idle(9);
    check_val("r9 set wins", {31'd0, q1_busy}, 32'd1);

    // Fill two entries behind WB, then reset mid-cycle.
    drive(1, 5'd1, 32'h31, 1, 5'd13, 32'h21, 1, 5'd12, 5'd12);
    cycle();
    drive(1, 5'd2, 32'h32, 1, 5'd14, 32'h22, 0, 0, 5'd12);
    cycle();
    drive(1, 5'd2, 32'h33, 1, 5'd15, 32'h23, 1, 5'd16, 5'd12);
    #2;
    rst = 1'b1;
    #1;
    check_val("mid-reset rf_we", {31'd0, rf_we}, 32'd0);
    check_val("mid-reset mc_ready", {31'd0, mc_ready}, 32'd1);
    check_val("mid-reset wb_stall", {31'd0, wb_stall}, 32'd0);
    check_val("mid-reset q1_busy", {31'd0, q1_busy}, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(12);
    idle(13);
    idle(9);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      cycle();
    end
    repeat (4) idle(5'($urandom_range(0, 7)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
